// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes, key indices and sizing helper for game_ctrl
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_PLAY     = 3'd1,
    ST_DYING    = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_RESPAWN  = 3'd4,
    ST_CLEAR    = 3'd5
  } state_t;

  localparam int NUM_KEYS    = 4;
  localparam int KEY_RESTART = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int timer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// rtl/game_ctrl_frame_timer.sv - frame_tick-driven counter with clear, terminal-count flag and wrap
module game_ctrl_frame_timer #(
  parameter int LAST = 29,
  parameter int W    = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == W'(LAST));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game-flow sequencer: world enable, sprite re-init pulse, overlays, death count
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES = 30,
  parameter int BLINK_FRAMES = 16,
  parameter int RESTART_KEY  = KEY_RESTART,
  parameter int CNT_W        = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_tick,
  input  logic [NUM_KEYS-1:0] i_keys,
  input  logic                i_hit,
  input  logic                i_goal,
  output logic [2:0]          o_state,
  output logic                o_world_en,
  output logic                o_obj_rst,
  output logic                o_ovl_gameover,
  output logic                o_ovl_clear,
  output logic [CNT_W-1:0]    o_death_cnt
);

  localparam int DW = timer_w(DEATH_FRAMES);
  localparam int BW = timer_w(BLINK_FRAMES);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_KEYS-1:0] r_keys_q;
  logic [NUM_KEYS-1:0] w_press;
  logic                w_restart;
  logic                w_dying_tc;
  logic                w_blink_tc;

  logic                r_world_en, r_obj_rst, r_ovl_go, r_ovl_clr;
  logic [CNT_W-1:0]    r_death_cnt;
  logic                w_world_en_d, w_obj_rst_d, w_ovl_go_d, w_ovl_clr_d;
  logic [CNT_W-1:0]    w_death_d;

  assign w_press   = i_keys & ~r_keys_q;
  assign w_restart = w_press[RESTART_KEY];

  // Timers are held clear outside their state, so entry always starts from zero
  game_ctrl_frame_timer #(.LAST(DEATH_FRAMES - 1), .W(DW)) u_death_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state != ST_DYING),
    .i_tick  (i_frame_tick),
    .o_tc    (w_dying_tc)
  );

  game_ctrl_frame_timer #(.LAST(BLINK_FRAMES - 1), .W(BW)) u_blink_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state != ST_GAMEOVER),
    .i_tick  (i_frame_tick),
    .o_tc    (w_blink_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_TITLE;
      r_keys_q <= '0;
    end else begin
      r_state  <= w_next;
      r_keys_q <= i_keys;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_TITLE:    if (|w_press) w_next = ST_RESPAWN;
      ST_RESPAWN:  if (i_frame_tick) w_next = ST_PLAY;
      ST_PLAY: begin
        if (i_hit)          w_next = ST_DYING;
        else if (i_goal)    w_next = ST_CLEAR;
        else if (w_restart) w_next = ST_RESPAWN;
      end
      ST_DYING:    if (i_frame_tick && w_dying_tc) w_next = ST_GAMEOVER;
      ST_GAMEOVER: if (w_restart) w_next = ST_RESPAWN;
      ST_CLEAR:    if (w_restart) w_next = ST_RESPAWN;
      default:     w_next = ST_TITLE;
    endcase
  end

  // Output values for the coming state, registered below so they track o_state
  always_comb begin
    w_world_en_d = (w_next == ST_PLAY);
    w_obj_rst_d  = (w_next == ST_RESPAWN) && (r_state != ST_RESPAWN);
    w_ovl_clr_d  = (w_next == ST_CLEAR);
    w_ovl_go_d   = 1'b0;
    if (w_next == ST_GAMEOVER) begin
      if (r_state != ST_GAMEOVER)          w_ovl_go_d = 1'b1;
      else if (i_frame_tick && w_blink_tc) w_ovl_go_d = ~r_ovl_go;
      else                                 w_ovl_go_d = r_ovl_go;
    end
    w_death_d = r_death_cnt;
    if (r_state == ST_PLAY && i_hit && r_death_cnt != {CNT_W{1'b1}}) begin
      w_death_d = r_death_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_world_en  <= 1'b0;
      r_obj_rst   <= 1'b0;
      r_ovl_go    <= 1'b0;
      r_ovl_clr   <= 1'b0;
      r_death_cnt <= '0;
    end else begin
      r_world_en  <= w_world_en_d;
      r_obj_rst   <= w_obj_rst_d;
      r_ovl_go    <= w_ovl_go_d;
      r_ovl_clr   <= w_ovl_clr_d;
      r_death_cnt <= w_death_d;
    end
  end

  assign o_state        = r_state;
  assign o_world_en     = r_world_en;
  assign o_obj_rst      = r_obj_rst;
  assign o_ovl_gameover = r_ovl_go;
  assign o_ovl_clear    = r_ovl_clr;
  assign o_death_cnt    = r_death_cnt;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl against a frame-counting reference model
module tb_game_ctrl;

  localparam int DEATH = 30;
  localparam int BLINK = 16;
  localparam int SAT   = 1023;
  localparam int M_TITLE = 0, M_PLAY = 1, M_DYING = 2, M_GO = 3, M_RESPAWN = 4, M_CLEAR = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] keys = '0;
  logic       hit = 1'b0;
  logic       goal = 1'b0;
  logic [2:0] state;
  logic       world_en, obj_rst, ovl_gameover, ovl_clear;
  logic [9:0] death_cnt;

  always #5 clk = ~clk;

  game_ctrl #(
    .DEATH_FRAMES (DEATH),
    .BLINK_FRAMES (BLINK),
    .RESTART_KEY  (3),
    .CNT_W        (10)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_frame_tick   (frame_tick),
    .i_keys         (keys),
    .i_hit          (hit),
    .i_goal         (goal),
    .o_state        (state),
    .o_world_en     (world_en),
    .o_obj_rst      (obj_rst),
    .o_ovl_gameover (ovl_gameover),
    .o_ovl_clear    (ovl_clear),
    .o_death_cnt    (death_cnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       we;
    logic       orst;
    logic       ogo;
    logic       oclr;
    logic [9:0] dc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: game mode plus frames elapsed since entering DYING / GAMEOVER
  int         m_mode = M_TITLE;
  logic [3:0] m_prev = '0;
  int         m_deaths = 0;
  int         m_dticks = 0;
  int         m_gticks = 0;
  bit         m_orst = 1'b0;

  task automatic model_step(input logic r, input logic [3:0] k, input logic h, input logic g,
                            input logic t, output exp_t e);
    logic [3:0] p;
    if (!r) begin
      m_mode = M_TITLE; m_prev = '0; m_deaths = 0; m_dticks = 0; m_gticks = 0; m_orst = 1'b0;
    end else begin
      p = k & ~m_prev;
      m_prev = k;
      m_orst = 1'b0;
      case (m_mode)
        M_TITLE:   if (p != 4'd0) begin m_mode = M_RESPAWN; m_orst = 1'b1; end
        M_RESPAWN: if (t) m_mode = M_PLAY;
        M_PLAY: begin
          if (h) begin
            m_mode = M_DYING; m_dticks = 0;
            if (m_deaths < SAT) m_deaths = m_deaths + 1;
          end else if (g) m_mode = M_CLEAR;
          else if (p[3]) begin m_mode = M_RESPAWN; m_orst = 1'b1; end
        end
        M_DYING: if (t) begin
          m_dticks = m_dticks + 1;
          if (m_dticks == DEATH) begin m_mode = M_GO; m_gticks = 0; end
        end
        M_GO: begin
          if (p[3]) begin m_mode = M_RESPAWN; m_orst = 1'b1; end
          else if (t) m_gticks = m_gticks + 1;
        end
        M_CLEAR: if (p[3]) begin m_mode = M_RESPAWN; m_orst = 1'b1; end
        default: m_mode = M_TITLE;
      endcase
    end
    e.st   = 3'(m_mode);
    e.we   = (m_mode == M_PLAY);
    e.orst = m_orst;
    e.ogo  = (m_mode == M_GO) && (((m_gticks / BLINK) % 2) == 0);
    e.oclr = (m_mode == M_CLEAR);
    e.dc   = 10'(m_deaths);
  endtask

  task automatic drive(input logic r, input logic [3:0] k, input logic h, input logic g,
                       input logic t);
    exp_t e;
    @(negedge clk);
    rst_n = r; keys = k; hit = h; goal = g; frame_tick = t;
    model_step(r, k, h, g, t, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic t);
    for (int i = 0; i < n; i++) drive(1'b1, 4'd0, 1'b0, 1'b0, t);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", state, e.st);
        chk("world_en", world_en, e.we);
        chk("obj_rst", obj_rst, e.orst);
        chk("ovl_gameover", ovl_gameover, e.ogo);
        chk("ovl_clear", ovl_clear, e.oclr);
        chk("death_cnt", death_cnt, e.dc);
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    // start, respawn pulse, frame-aligned entry to PLAY
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    // death, delay, blink
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    ticks(DEATH + 2 * BLINK + 4);
    // restart from game over
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // hit beats goal
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    ticks(DEATH);
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    // goal alone, then restart from clear
    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    // restart held through dying and game over is ignored until re-pressed
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEATH + 6; i++) drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    // drive the death counter into saturation
    for (int n = 0; n < SAT + 3; n++) begin
      drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < DEATH; i++) drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    end
    // asynchronous reset in the middle of dying
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      drive(($urandom_range(0, 499) != 0), k, ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(2, 1'b0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
